i2c_reg_ctrl: RTL and testbench
===============================

Name: i2c_reg_ctrl

Overview:
Sequences transactions from i2c_peripheral into a byte-wide register bank on the system clock. Decodes the byte stream: header, then memory address, then data bytes. Generates register write strobes for master writes. Prefetches register reads to drive the peripheral's tx byte for master reads, including repeated-start reads. Sits between i2c_peripheral (SCL domain) and the application register file (clk domain).

Parameters:
NUM_REGS, 128, number of valid register addresses (1..256); pointer wraps at NUM_REGS-1
SYNC_STAGES, 2, flops per synchronizer for SCL-domain toggles (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
i2c_rx  in  8  last received byte from peripheral; stable for >=SYNC_STAGES+2 clk after i2c_rx_tgl flips
i2c_rx_tgl  in  1  toggles once per received non-header byte the peripheral ACKed
i2c_hdr_tgl  in  1  toggles when the peripheral matched device address; i2c_rw valid at that point
i2c_rw  in  1  R/W bit of last matched header (1 = read)
i2c_txreq_tgl  in  1  toggles when the master ACKed a tx byte and the peripheral needs the next one
i2c_start_tgl  in  1  toggles on each START or repeated START
i2c_stop_tgl  in  1  toggles on each STOP
tx  out  8  byte presented to the peripheral for master reads
reg_addr  out  8  register address
reg_wdata  out  8  write data
reg_we  out  1  one-cycle write strobe
reg_re  out  1  one-cycle read strobe; reg_rdata is valid the next cycle
reg_rdata  in  8  register read data, 1-cycle latency after reg_re
addr_err  out  1  sticky flag: access to address >= NUM_REGS; cleared only by reset
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: tx=8'hFF, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, addr_err=0, busy=0, ptr=0, state=IDLE.
- Toggle inputs: each passes through a SYNC_STAGES synchronizer, then an edge detector, producing a one-clk event. i2c_rx and i2c_rw are sampled on the clk in which their event fires.
- Event priority in one cycle: rx > txreq > hdr > stop > start. A lower-priority event is processed in the same cycle after the higher-priority one. Example: rx with stop writes the byte, then state becomes IDLE.
- States:
  - IDLE: hdr event with rw=0 -> ADDR; hdr event with rw=1 -> RD_FETCH.
  - ADDR: rx event -> ptr=i2c_rx, go to WRITE. No reg_we for this byte.
  - WRITE: rx event -> reg_we=1, reg_addr=ptr, reg_wdata=i2c_rx, ptr=ptr+1 (wraps to 0 after NUM_REGS-1).
  - RD_FETCH: reg_re=1, reg_addr=ptr, go to RD_LOAD.
  - RD_LOAD: tx=reg_rdata, ptr=ptr+1 with wrap, go to READ.
  - READ: txreq event -> RD_FETCH.
- Latency: tx is updated 2 clk after entry to RD_FETCH. End-to-end from hdr toggle to tx valid is at most SYNC_STAGES+4 clk; the peripheral must allow this before the first data bit.
- Out-of-range pointer (ptr >= NUM_REGS, set by an ADDR byte):
  - Writes are dropped (no reg_we) and addr_err is set.
  - Reads issue no reg_re, load tx=8'hFF and set addr_err.
  - ptr still increments; wrap applies only when ptr == NUM_REGS-1, otherwise increment modulo 256.
- STOP from any state -> IDLE; ptr retained.
- START or repeated START from any state -> IDLE; ptr retained. A write header plus memory address, followed by repeated START and a read header, therefore reads from that address.
- hdr event in ADDR, WRITE or READ (no START seen) -> re-enter as from IDLE.
- txreq or rx event in IDLE is ignored; no strobes are issued.
- reset_n low mid-transaction: outputs return to reset values immediately (asynchronous). Synchronizer flops also reset to 0, so the peripheral's toggles must also be reset.

Test Plan:
1. Write header, rx 8'h67, rx 8'h66, stop -> single reg_we with reg_addr=8'h67, reg_wdata=8'h66; ptr=8'h68; state IDLE.
2. Write header, rx 8'h67, repeated START, read header with reg[0x67]=8'hA5 -> reg_re at addr 8'h67; tx=8'hA5 within SYNC_STAGES+4 clk of hdr toggle.
3. Read burst with reg[0x67..0x69]=11,22,33 and two txreq events -> tx sequence 8'h11, 8'h22, 8'h33 (3 reg_re).
4. NUM_REGS=128, write header, rx 8'h7F, rx 8'hAA, rx 8'hBB -> writes to 8'h7F=AA, then 8'h00=BB (wrap); addr_err stays 0.
5. Write header, rx 8'hC0, rx 8'h01 -> no reg_we; addr_err=1. Then a read at ptr 8'hC1 -> tx=8'hFF.
6. Assert reset_n low mid-WRITE, then release and apply rx toggle -> all outputs at reset values; no reg_we; busy=0.

Source files
------------

// File: rtl/i2c_reg_ctrl.sv
// Bridges i2c_peripheral byte events (SCL domain) onto a byte-wide register bank (clk domain).
// tx is ready SYNC_STAGES+3 clk after a read header toggle; no backpressure, events are never stalled.
module i2c_reg_ctrl #(
  parameter int NUM_REGS    = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] i2c_rx,
  input  logic       i2c_rx_tgl,
  input  logic       i2c_hdr_tgl,
  input  logic       i2c_rw,
  input  logic       i2c_txreq_tgl,
  input  logic       i2c_start_tgl,
  input  logic       i2c_stop_tgl,
  output logic [7:0] tx,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       addr_err,
  output logic       busy
);

  localparam int EV_RX    = 0;
  localparam int EV_TXREQ = 1;
  localparam int EV_HDR   = 2;
  localparam int EV_STOP  = 3;
  localparam int EV_START = 4;

  localparam logic [8:0] NREGS    = 9'(NUM_REGS);
  localparam logic [7:0] LAST_REG = 8'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, WRITE, RD_FETCH, RD_LOAD, READ
  } state_t;

  logic [4:0]                  tgl_in;
  logic [4:0][SYNC_STAGES-1:0] sync_q;
  logic [4:0]                  prev_q;
  logic [4:0]                  ev;

  state_t     state, st_n;
  logic [7:0] ptr, ptr_n;
  logic [7:0] tx_n, addr_n, wdata_n;
  logic       we_n, re_n, err_n;

  assign tgl_in = {i2c_start_tgl, i2c_stop_tgl, i2c_hdr_tgl, i2c_txreq_tgl, i2c_rx_tgl};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], tgl_in[i]};
        prev_q[i] <= sync_q[i][SYNC_STAGES-1];
      end
    end
  end

  always_comb begin
    ev = '0;
    for (int i = 0; i < 5; i++) ev[i] = sync_q[i][SYNC_STAGES-1] ^ prev_q[i];
  end

  function automatic logic in_range(input logic [7:0] p);
    return {1'b0, p} < NREGS;
  endfunction

  function automatic logic [7:0] ptr_inc(input logic [7:0] p);
    return (p == LAST_REG) ? 8'h00 : p + 8'h01;
  endfunction

  // Events are applied in priority order, each seeing the state left by the previous one.
  always_comb begin
    st_n    = state;
    ptr_n   = ptr;
    tx_n    = tx;
    addr_n  = reg_addr;
    wdata_n = reg_wdata;
    we_n    = 1'b0;
    re_n    = 1'b0;
    err_n   = addr_err;

    case (state)
      RD_FETCH: st_n = RD_LOAD;
      RD_LOAD: begin
        tx_n  = in_range(ptr) ? reg_rdata : 8'hFF;
        ptr_n = ptr_inc(ptr);
        st_n  = READ;
      end
      default: ;
    endcase

    if (ev[EV_RX]) begin
      if (st_n == ADDR) begin
        ptr_n = i2c_rx;
        st_n  = WRITE;
      end else if (st_n == WRITE) begin
        if (in_range(ptr_n)) begin
          we_n    = 1'b1;
          addr_n  = ptr_n;
          wdata_n = i2c_rx;
        end else begin
          err_n = 1'b1;
        end
        ptr_n = ptr_inc(ptr_n);
      end
    end

    if (ev[EV_TXREQ] && st_n == READ) st_n = RD_FETCH;

    if (ev[EV_HDR] && (st_n == IDLE || st_n == ADDR || st_n == WRITE || st_n == READ))
      st_n = i2c_rw ? RD_FETCH : ADDR;

    if (ev[EV_STOP])  st_n = IDLE;
    if (ev[EV_START]) st_n = IDLE;

    // The read strobe is launched on entry so reg_rdata lands while in RD_LOAD.
    if (st_n == RD_FETCH) begin
      if (in_range(ptr_n)) begin
        re_n   = 1'b1;
        addr_n = ptr_n;
      end else begin
        err_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= 8'h00;
      tx        <= 8'hFF;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      addr_err  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= st_n;
      ptr       <= ptr_n;
      tx        <= tx_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
      reg_we    <= we_n;
      reg_re    <= re_n;
      addr_err  <= err_n;
      busy      <= (st_n != IDLE);
    end
  end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl: expected strobes go into queues, a negedge monitor checks them.
module tb_i2c_reg_ctrl;

  localparam int NUM_REGS    = 128;
  localparam int SYNC_STAGES = 2;
  localparam int GAP         = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] i2c_rx;
  logic       i2c_rx_tgl, i2c_hdr_tgl, i2c_rw, i2c_txreq_tgl, i2c_start_tgl, i2c_stop_tgl;
  logic [7:0] tx, reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, addr_err, busy;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  logic [7:0] mem [256];
  wr_t        mon_w;
  logic [7:0] mon_a;

  int n_tests = 0;
  int n_fail  = 0;

  i2c_reg_ctrl #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i2c_rx       (i2c_rx),
    .i2c_rx_tgl   (i2c_rx_tgl),
    .i2c_hdr_tgl  (i2c_hdr_tgl),
    .i2c_rw       (i2c_rw),
    .i2c_txreq_tgl(i2c_txreq_tgl),
    .i2c_start_tgl(i2c_start_tgl),
    .i2c_stop_tgl (i2c_stop_tgl),
    .tx           (tx),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_we       (reg_we),
    .reg_re       (reg_re),
    .reg_rdata    (reg_rdata),
    .addr_err     (addr_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Register file model: one-cycle read latency.
  always @(posedge clk) begin
    if (reg_we) mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= mem[reg_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (reg_we) begin
        if (wq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_we: got write addr %0h data %0h, required none", reg_addr, reg_wdata);
        end else begin
          mon_w = wq.pop_front();
          chk("we_addr", {24'h0, reg_addr}, {24'h0, mon_w.a});
          chk("we_data", {24'h0, reg_wdata}, {24'h0, mon_w.d});
        end
      end
      if (reg_re) begin
        if (rq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_re: got read addr %0h, required none", reg_addr);
        end else begin
          mon_a = rq.pop_front();
          chk("re_addr", {24'h0, reg_addr}, {24'h0, mon_a});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hdr(input logic rw);
    i2c_rw = rw;
    i2c_hdr_tgl = ~i2c_hdr_tgl;
    tick(GAP);
  endtask

  task automatic rx(input logic [7:0] b);
    i2c_rx = b;
    i2c_rx_tgl = ~i2c_rx_tgl;
    tick(GAP);
  endtask

  task automatic start_c();
    i2c_start_tgl = ~i2c_start_tgl;
    tick(GAP);
  endtask

  task automatic stop_c();
    i2c_stop_tgl = ~i2c_stop_tgl;
    tick(GAP);
  endtask

  task automatic txreq();
    i2c_txreq_tgl = ~i2c_txreq_tgl;
    tick(GAP);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    mem[a] <= d;
    tick(1);
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_tx"},       {24'h0, tx},        32'hFF);
    chk({tag, "_addr"},     {24'h0, reg_addr},  32'h0);
    chk({tag, "_wdata"},    {24'h0, reg_wdata}, 32'h0);
    chk({tag, "_we"},       {31'h0, reg_we},    32'h0);
    chk({tag, "_re"},       {31'h0, reg_re},    32'h0);
    chk({tag, "_addr_err"}, {31'h0, addr_err},  32'h0);
    chk({tag, "_busy"},     {31'h0, busy},      32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reg_rdata     = 8'h00;
    reset_n       = 1'b0;
    i2c_rx        = 8'h00;
    i2c_rx_tgl    = 1'b0;
    i2c_hdr_tgl   = 1'b0;
    i2c_rw        = 1'b0;
    i2c_txreq_tgl = 1'b0;
    i2c_start_tgl = 1'b0;
    i2c_stop_tgl  = 1'b0;
    tick(3);
    reset_values("rst");
    reset_n = 1'b1;
    tick(2);

    // txreq and rx in IDLE must not strobe anything
    txreq();
    rx(8'h12);
    chk("idle_busy", {31'h0, busy}, 32'h0);

    // 1: simple write, then read back the incremented pointer
    start_c();
    hdr(1'b0);
    chk("wr_busy", {31'h0, busy}, 32'h1);
    rx(8'h67);
    wq.push_back('{a: 8'h67, d: 8'h66});
    rx(8'h66);
    stop_c();
    chk("stop_busy", {31'h0, busy}, 32'h0);
    preload(8'h68, 8'h3C);
    start_c();
    rq.push_back(8'h68);
    hdr(1'b1);
    chk("ptr_after_write_tx", {24'h0, tx}, 32'h3C);
    stop_c();

    // 2: write header + address, repeated START, read; tx within SYNC_STAGES+4 clk
    preload(8'h67, 8'hA5);
    start_c();
    hdr(1'b0);
    rx(8'h67);
    start_c();
    rq.push_back(8'h67);
    i2c_rw = 1'b1;
    i2c_hdr_tgl = ~i2c_hdr_tgl;
    tick(SYNC_STAGES + 4);
    chk("rs_read_tx", {24'h0, tx}, 32'hA5);
    tick(GAP);
    stop_c();

    // 3: burst read 0x67..0x69
    preload(8'h67, 8'h11);
    preload(8'h68, 8'h22);
    preload(8'h69, 8'h33);
    start_c();
    hdr(1'b0);
    rx(8'h67);
    start_c();
    rq.push_back(8'h67);
    hdr(1'b1);
    chk("burst_tx0", {24'h0, tx}, 32'h11);
    rq.push_back(8'h68);
    txreq();
    chk("burst_tx1", {24'h0, tx}, 32'h22);
    rq.push_back(8'h69);
    txreq();
    chk("burst_tx2", {24'h0, tx}, 32'h33);
    stop_c();

    // 4: pointer wraps after NUM_REGS-1
    start_c();
    hdr(1'b0);
    rx(8'h7F);
    wq.push_back('{a: 8'h7F, d: 8'hAA});
    rx(8'hAA);
    wq.push_back('{a: 8'h00, d: 8'hBB});
    rx(8'hBB);
    stop_c();
    chk("wrap_addr_err", {31'h0, addr_err}, 32'h0);
    chk("wrap_mem0", {24'h0, mem[0]}, 32'hBB);

    // 5: out-of-range write dropped, out-of-range read returns FF
    start_c();
    hdr(1'b0);
    rx(8'hC0);
    rx(8'h01);
    chk("oor_addr_err", {31'h0, addr_err}, 32'h1);
    start_c();
    hdr(1'b1);
    chk("oor_read_tx", {24'h0, tx}, 32'hFF);
    stop_c();

    // 6: asynchronous reset in the middle of a write
    start_c();
    hdr(1'b0);
    rx(8'h10);
    #3;
    reset_n       = 1'b0;
    i2c_rx_tgl    = 1'b0;
    i2c_hdr_tgl   = 1'b0;
    i2c_txreq_tgl = 1'b0;
    i2c_start_tgl = 1'b0;
    i2c_stop_tgl  = 1'b0;
    #1;
    reset_values("arst");
    tick(2);
    reset_n = 1'b1;
    tick(2);
    rx(8'h55);
    reset_values("post_rst");

    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
